frame_buffer: RTL
=================

Name: frame_buffer

Overview:
- Double-buffered 1-bit-per-pixel frame memory, directly downstream of the GPU rasteriser.
- Accepts the GPU pixel-write stream (wr_en/wr_addr/wr_data) into the back bank.
- Serves the video scanout reads from the front bank.
- Swaps banks only on a frame boundary and optionally clears the new back bank, so the op producer can draw the next frame on a blank canvas.

Parameters:
- HOR_ACTIVE_PIXELS, 640, visible pixels per line; linear address = y*HOR_ACTIVE_PIXELS + x.
- VER_ACTIVE_PIXELS, 480, visible lines; bank depth N = HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS.
- CLEAR_ON_SWAP, 1, 1 = fill the new back bank with CLEAR_COLOR after every swap.
- CLEAR_COLOR, 0, fill value used by the clear engine.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- ce  in  1  clock enable; when 0, all state, counters and rd_data hold. Reset still acts.
- wr_en  in  1  pixel write strobe from GPU.
- wr_addr  in  21  linear pixel address from GPU.
- wr_data  in  1  pixel value from GPU.
- rd_en  in  1  scanout read strobe.
- rd_addr  in  21  scanout linear address.
- rd_data  out  1  registered pixel from the front bank.
- frame_start  in  1  one-cycle pulse from video timing at start of vertical blank.
- swap_req  in  1  one-cycle pulse: back bank is complete.
- swap_pending  out  1  swap accepted, waiting for frame_start.
- clear_busy  out  1  clear engine running.
- front_sel  out  1  index of bank being scanned out; back bank = ~front_sel.
- ready  out  1  = !swap_pending && !clear_busy; the op producer issues GPU ops only while high.

Behaviour:
- Reset (rst==0 at posedge):
  - Outputs: front_sel=0, rd_data=0, swap_pending=0, clear_busy=0, ready=1.
  - Internal: state=IDLE, clr_addr=0.
  - Bank contents are not reset.
  - Reset mid-clear or mid-swap aborts the operation; back-bank contents are then undefined.
- Write path (ce=1, wr_en=1, wr_addr<N): back[wr_addr] <= wr_data, using front_sel as registered before the edge.
  - wr_addr>=N is silently dropped.
  - Writes are accepted in every state.
- Read path (ce=1, rd_en=1): rd_data <= front[rd_addr] on the next edge (1-cycle latency), using front_sel as registered before the edge.
  - rd_addr>=N returns 0.
  - rd_en=0: rd_data holds.
- FSM states IDLE, SWAP_WAIT, CLEAR; transitions only when ce=1.
  - IDLE:
    - swap_req=1 -> SWAP_WAIT, swap_pending=1.
    - frame_start in the same cycle as swap_req does not swap; the swap waits for the next frame_start.
  - SWAP_WAIT:
    - On frame_start: front_sel toggles, swap_pending=0.
    - Then -> CLEAR with clr_addr=0, clear_busy=1, if CLEAR_ON_SWAP=1; else -> IDLE.
    - swap_req is ignored here.
  - CLEAR:
    - Each cycle with wr_en=0: back[clr_addr] <= CLEAR_COLOR, clr_addr++.
    - Each cycle with wr_en=1: the GPU write wins, clr_addr holds (stall).
    - After writing clr_addr=N-1: -> IDLE, clear_busy=0, clr_addr=0.
    - swap_req and frame_start are ignored here.
    - Clear duration is exactly N cycles when there are no GPU writes and ce is held high.
- Same-edge events:
  - Write and swap in the same cycle: the write lands in the pre-swap back bank, i.e. the newly displayed frame.
  - Read and swap in the same cycle: the read comes from the pre-swap front bank.
- Storage: two N-deep x1 arrays with synchronous read, inferable as block RAM.
- Clear-port contention: the clear engine uses the same write port as the GPU, so there is at most one back-bank write per cycle.

Test Plan:
- Reset, then H=8,V=4, CLEAR_ON_SWAP=0. Write addr 5=1 -> reading addr 5 returns 0 (front untouched). swap_req, then frame_start -> front_sel=1; read addr 5 returns 1 one cycle after rd_en.
- swap_req and frame_start in the same cycle -> front_sel unchanged, swap_pending=1. Next frame_start -> front_sel toggles, swap_pending=0, ready=1.
- CLEAR_ON_SWAP=1, H=8,V=4, back bank pre-filled with 1s, swap -> clear_busy high exactly 32 cycles. Swap again -> all 32 reads return 0.
- During CLEAR, GPU writes addr 31=1 at clr_addr=3 -> clear stalls one cycle and still ends with addr 31=0. Total busy = 33 cycles.
- Boundary addresses: wr_addr=32 (N) with wr_data=1 -> no bank changes. rd_addr=40 -> rd_data=0. wr_addr=0 and 31 written and read back after swap.
- rst driven low at clr_addr=10 -> next cycle clear_busy=0, state IDLE, front_sel=0, rd_data=0. ce=0 for 5 cycles mid-clear -> clr_addr and rd_data frozen.

Source files
------------

// File: rtl/frame_buffer.sv
// Double-buffered 1-bpp frame memory: GPU writes the back bank, scanout reads the front bank.
// Banks swap on frame_start after a swap_req, then the new back bank is optionally cleared.
module frame_buffer #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  parameter bit          CLEAR_ON_SWAP     = 1'b1,
  parameter bit          CLEAR_COLOR       = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        wr_en,
  input  logic [20:0] wr_addr,
  input  logic        wr_data,
  input  logic        rd_en,
  input  logic [20:0] rd_addr,
  output logic        rd_data,
  input  logic        frame_start,
  input  logic        swap_req,
  output logic        swap_pending,
  output logic        clear_busy,
  output logic        front_sel,
  output logic        ready
);

  localparam int unsigned N        = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int unsigned AW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [20:0] NumPix   = 21'(N);
  localparam logic [AW-1:0] LastAddr = AW'(N - 1);

  typedef enum logic [1:0] {StIdle, StSwapWait, StClear} state_e;

  state_e        state_q, state_d;
  logic          front_sel_q, front_sel_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          rd_data_q;

  logic bank0 [N];
  logic bank1 [N];

  logic          wr_hit, rd_hit;
  logic          we, we_data;
  logic [AW-1:0] we_addr, rd_idx;

  assign wr_hit = wr_en && (wr_addr < NumPix);
  assign rd_hit = rd_addr < NumPix;
  assign rd_idx = rd_addr[AW-1:0];

  // Single back-bank write port shared by GPU and clear engine; GPU has priority.
  always_comb begin
    we      = 1'b0;
    we_addr = clr_addr_q;
    we_data = CLEAR_COLOR;
    if (rst && ce) begin
      if (wr_hit) begin
        we      = 1'b1;
        we_addr = wr_addr[AW-1:0];
        we_data = wr_data;
      end else if (state_q == StClear && !wr_en) begin
        we = 1'b1;
      end
    end
  end

  // Back bank is the one not being scanned out.
  always_ff @(posedge clk) begin
    if (we && front_sel_q) bank0[we_addr] <= we_data;
  end

  always_ff @(posedge clk) begin
    if (we && !front_sel_q) bank1[we_addr] <= we_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= 1'b0;
    end else if (ce && rd_en) begin
      rd_data_q <= rd_hit ? (front_sel_q ? bank1[rd_idx] : bank0[rd_idx]) : 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    clr_addr_d  = clr_addr_q;
    if (ce) begin
      unique case (state_q)
        StIdle: begin
          if (swap_req) state_d = StSwapWait;
        end
        StSwapWait: begin
          if (frame_start) begin
            front_sel_d = ~front_sel_q;
            clr_addr_d  = '0;
            state_d     = CLEAR_ON_SWAP ? StClear : StIdle;
          end
        end
        StClear: begin
          if (!wr_en) begin
            if (clr_addr_q == LastAddr) begin
              state_d    = StIdle;
              clr_addr_d = '0;
            end else begin
              clr_addr_d = clr_addr_q + AW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      front_sel_q <= 1'b0;
      clr_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      clr_addr_q  <= clr_addr_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign front_sel    = front_sel_q;
  assign swap_pending = (state_q == StSwapWait);
  assign clear_busy   = (state_q == StClear);
  assign ready        = !swap_pending && !clear_busy;

endmodule
